// File: rtl/mult_acc_stage.sv
// Accumulates unsigned multiplier products into per-group sums.
// A group closes on in_last or after MAX_TERMS beats, and its result is held until downstream accepts it.
module mult_acc_stage #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_TERMS - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_ovf_q, out_ovf_d;

    logic               in_fire;
    logic               out_fire;
    logic               close;
    logic [ACC_W:0]     nxt;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign close     = in_last || (cnt_q == LAST_IDX);

    // acc_q is already zero while holding, so a beat accepted in HOLD starts a fresh group.
    assign nxt = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};

    assign out_sum   = sum_q;
    assign out_count = count_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        count_d   = count_q;
        out_ovf_d = out_ovf_q;

        if (out_fire) begin
            state_d = ACCUM;
        end

        if (in_fire) begin
            if (close) begin
                sum_d     = nxt[ACC_W-1:0];
                count_d   = cnt_q + 1'b1;
                out_ovf_d = ovf_q || nxt[ACC_W];
                acc_d     = '0;
                cnt_d     = '0;
                ovf_d     = 1'b0;
                state_d   = HOLD;
            end else begin
                acc_d = nxt[ACC_W-1:0];
                cnt_d = cnt_q + 1'b1;
                ovf_d = ovf_q || nxt[ACC_W];
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so all registers sample together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            count_q   <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            out_ovf_q <= out_ovf_d;
        end
    end

endmodule
